rpn_tokenizer: RTL

- Upstream stage of the RPN calculator. Converts a stream of ASCII characters from the host/UART side into the calculator's token stream.
- Decimal digit runs become 32-bit numeric tokens.
- The characters + - * / = become operator tokens, flagged by token_is_operator.
- Drives the calculator's input_stb/input_data/is_input_operator/input_ack handshake directly.

---
 rtl/rpn_tokenizer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/rpn_tokenizer.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_tokenizer
//  Description : ASCII character stream to RPN token stream. Decimal digit
//                runs become WIDTH-bit number tokens; + - * / = become
//                operator tokens (codes 0..4). Illegal characters and
//                over-long digit runs set a sticky syntax_err.
//                Optional build macro TOKENIZER_OVF_EN: saturate the
//                accumulator to all-ones (and flag syntax_err) on numeric
//                overflow instead of wrapping modulo 2^WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module rpn_tokenizer #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             char_stb,
    input  logic [7:0]       char_data,
    output logic             char_ack,
    output logic             token_stb,
    output logic [WIDTH-1:0] token_data,
    output logic             token_is_operator,
    input  logic             token_ack,
    output logic             syntax_err
);

    localparam int              CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_NUM      = 2'd1,
        S_EMIT_NUM = 2'd2,
        S_EMIT_OP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_code_q;
    logic               op_pend_q;
    logic               char_ack_q;
    logic               token_stb_q;
    logic [WIDTH-1:0]   token_data_q;
    logic               token_is_op_q;
    logic               syntax_err_q;

    logic               is_digit;
    logic               is_sep;
    logic               is_op;
    logic [2:0]         op_code;
    logic [3:0]         digit_val;
    logic               can_consume;
    logic [WIDTH-1:0]   acc_d;
    logic               acc_sat_d;

    // A character is only consumed when no ack is in flight: during the ack
    // cycle the sender still holds the old character on the bus.
    assign can_consume = char_stb && !char_ack_q;

    // ASCII '0'..'9' carry their value in the low nibble.
    assign digit_val = char_data[3:0];
    assign is_digit  = (char_data >= 8'h30) && (char_data <= 8'h39);
    assign is_sep    = (char_data == 8'h20) || (char_data == 8'h0D) || (char_data == 8'h0A);

    // Operator classification and code lookup.
    always_comb begin
        is_op   = 1'b1;
        op_code = 3'd0;
        case (char_data)
            8'h2B:   op_code = 3'd0;   // '+'
            8'h2D:   op_code = 3'd1;   // '-'
            8'h2A:   op_code = 3'd2;   // '*'
            8'h2F:   op_code = 3'd3;   // '/'
            8'h3D:   op_code = 3'd4;   // '='
            default: is_op   = 1'b0;
        endcase
    end

`ifdef TOKENIZER_OVF_EN
    // Four guard bits hold any acc*10+digit result, so a nonzero guard
    // field means the value no longer fits in WIDTH bits.
    logic [WIDTH+3:0] acc_ext_d;
    assign acc_ext_d = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                     + {{WIDTH{1'b0}}, digit_val};
    assign acc_sat_d = |acc_ext_d[WIDTH+3:WIDTH];
    assign acc_d     = acc_sat_d ? {WIDTH{1'b1}} : acc_ext_d[WIDTH-1:0];
`else
    // Plain modulo-2^WIDTH accumulation.
    assign acc_sat_d = 1'b0;
    assign acc_d     = (acc_q << 3) + (acc_q << 1) + {{(WIDTH-4){1'b0}}, digit_val};
`endif

    // Tokenizer state machine with registered handshake outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            op_code_q     <= 3'd0;
            op_pend_q     <= 1'b0;
            char_ack_q    <= 1'b0;
            token_stb_q   <= 1'b0;
            token_data_q  <= '0;
            token_is_op_q <= 1'b0;
            syntax_err_q  <= 1'b0;
        end else begin
            char_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (can_consume) begin
                        if (is_digit) begin
                            acc_q      <= {{(WIDTH-4){1'b0}}, digit_val};
                            cnt_q      <= CNT_ONE;
                            state_q    <= S_NUM;
                            char_ack_q <= 1'b1;
                        end else if (is_op) begin
                            // Ack is deferred until the operator token is taken.
                            op_code_q <= op_code;
                            op_pend_q <= 1'b0;
                            state_q   <= S_EMIT_OP;
                        end else if (is_sep) begin
                            char_ack_q <= 1'b1;
                        end else begin
                            syntax_err_q <= 1'b1;
                            char_ack_q   <= 1'b1;
                        end
                    end
                end

                S_NUM: begin
                    if (can_consume) begin
                        if (is_digit) begin
                            if (cnt_q == CNT_MAX) begin
                                // Too many digits: drop the whole number.
                                syntax_err_q <= 1'b1;
                                acc_q        <= '0;
                                cnt_q        <= '0;
                                state_q      <= S_IDLE;
                            end else begin
                                acc_q <= acc_d;
                                cnt_q <= cnt_q + CNT_ONE;
                                if (acc_sat_d) begin
                                    syntax_err_q <= 1'b1;
                                end
                            end
                            char_ack_q <= 1'b1;
                        end else if (is_op) begin
                            // Number first, then the operator; one ack at the end.
                            op_code_q <= op_code;
                            op_pend_q <= 1'b1;
                            state_q   <= S_EMIT_NUM;
                        end else if (is_sep) begin
                            op_pend_q <= 1'b0;
                            state_q   <= S_EMIT_NUM;
                        end else begin
                            syntax_err_q <= 1'b1;
                            acc_q        <= '0;
                            cnt_q        <= '0;
                            state_q      <= S_IDLE;
                            char_ack_q   <= 1'b1;
                        end
                    end
                end

                S_EMIT_NUM: begin
                    if (!token_stb_q) begin
                        token_stb_q   <= 1'b1;
                        token_data_q  <= acc_q;
                        token_is_op_q <= 1'b0;
                    end else if (token_ack) begin
                        token_stb_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        if (op_pend_q) begin
                            op_pend_q <= 1'b0;
                            state_q   <= S_EMIT_OP;
                        end else begin
                            state_q    <= S_IDLE;
                            char_ack_q <= 1'b1;
                        end
                    end
                end

                S_EMIT_OP: begin
                    if (!token_stb_q) begin
                        token_stb_q   <= 1'b1;
                        token_data_q  <= {{(WIDTH-3){1'b0}}, op_code_q};
                        token_is_op_q <= 1'b1;
                    end else if (token_ack) begin
                        token_stb_q <= 1'b0;
                        state_q     <= S_IDLE;
                        char_ack_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign char_ack          = char_ack_q;
    assign token_stb         = token_stb_q;
    assign token_data        = token_data_q;
    assign token_is_operator = token_is_op_q;
    assign syntax_err        = syntax_err_q;

endmodule
`default_nettype wire
